// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: valid/ready IF/ID stage with a 2-entry skid buffer and registered in_ready.
// Define PIPE_SKID_NOP_EN to present NOP_WORD / PC 0 whenever no valid entry is held.
module if_id_skid_reg #(
  parameter int          PC_W     = 32,
  parameter int          DATA_W   = 32,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occ
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t              state_q, state_d;
  logic [PC_W-1:0]     main_pc_q, skid_pc_q;
  logic [DATA_W-1:0]   main_data_q, skid_data_q;
  logic                ld_main, ld_skid, pop_skid;
  always_comb begin
    state_d  = state_q;
    ld_main  = 1'b0;
    ld_skid  = 1'b0;
    pop_skid = 1'b0;
    case (state_q)
      EMPTY: if (in_valid) begin
        state_d = ONE;
        ld_main = 1'b1;
      end
      ONE: if (in_valid) begin
        state_d = out_ready ? ONE : TWO;
        ld_main = out_ready;
        ld_skid = !out_ready;
      end else if (out_ready) begin
        state_d = EMPTY;
      end
      default: if (out_ready) begin
        state_d  = ONE;
        pop_skid = 1'b1;
      end
    endcase
    // flush wins: any beat accepted this cycle is dropped
    if (flush) begin
      state_d  = EMPTY;
      ld_main  = 1'b0;
      ld_skid  = 1'b0;
      pop_skid = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_pc_q   <= '0;
      main_data_q <= '0;
      skid_pc_q   <= '0;
      skid_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (ld_main || pop_skid) begin
        main_pc_q   <= pop_skid ? skid_pc_q : in_pc;
        main_data_q <= pop_skid ? skid_data_q : in_data;
      end
      if (ld_skid) begin
        skid_pc_q   <= in_pc;
        skid_data_q <= in_data;
      end
    end
  end
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign occ       = state_q;
`ifdef PIPE_SKID_NOP_EN
  assign out_pc   = out_valid ? main_pc_q : '0;
  assign out_data = out_valid ? main_data_q : DATA_W'(NOP_WORD);
`else
  assign out_pc   = main_pc_q;
  assign out_data = main_data_q;
`endif
endmodule
